// File: rtl/mul_slave_if.sv
// Bus-side signal bundle between a bus master and the multiplier slave.
// The master drives select/direction/address/data; the slave returns registered read data.
interface mul_slave_if;
  logic        s_sel;
  logic        s_wr;
  logic [7:0]  s_addr;
  logic [63:0] s_din;
  logic [63:0] s_dout;

  modport master (output s_sel, output s_wr, output s_addr, output s_din, input s_dout);
  modport slave  (input s_sel, input s_wr, input s_addr, input s_din, output s_dout);
endinterface

// File: rtl/mul_slave.sv
// Register front end for the Booth multiplier core: operands, start/clear pulses,
// captured product, status and interrupt.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_IDLE | no operation; operands writable, start accepted
//   ST_BUSY | core running; operands locked, waiting on done
//   ST_DONE | product latched; start ignored until cleared
module mul_slave (
  input  logic          clk,
  input  logic          reset_n,
  mul_slave_if.slave    bus,
  output logic          interrupt,
  output logic [63:0]   mul_multiplicand,
  output logic [63:0]   mul_multiplier,
  output logic          mul_start,
  output logic          mul_clear,
  input  logic [127:0]  mul_result,
  input  logic          mul_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic          intr_en;
  logic [127:0]  result;
  logic [63:0]   rd_data;
  logic [2:0]    idx;
  logic          mapped, wr_en, rd_en;
  logic          start_req, clear_req, done_take;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^bus.s_addr[2:0];

  assign mapped = (bus.s_addr[7:6] == 2'b00);
  assign idx    = bus.s_addr[5:3];
  assign wr_en  = bus.s_sel & bus.s_wr & mapped;
  assign rd_en  = bus.s_sel & ~bus.s_wr & mapped;

  assign start_req = wr_en && (idx == 3'd0) && bus.s_din[0] && (state_q == ST_IDLE);
  assign clear_req = wr_en && (idx == 3'd1) && bus.s_din[0];
  // A done level still high from the previous run must not complete the new one.
  assign done_take = (state_q == ST_BUSY) && mul_done && !mul_start && !clear_req;

  always_comb begin
    state_d = state_q;
    if (clear_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_req) state_d = ST_BUSY;
        ST_BUSY: if (done_take) state_d = ST_DONE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    rd_data = 64'h0;
    case (idx)
      3'd2:    rd_data = {62'h0, (state_q == ST_BUSY), (state_q == ST_DONE)};
      3'd3:    rd_data = {63'h0, intr_en};
      3'd4:    rd_data = mul_multiplicand;
      3'd5:    rd_data = mul_multiplier;
      3'd6:    rd_data = result[127:64];
      3'd7:    rd_data = result[63:0];
      default: rd_data = 64'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_start        <= 1'b0;
      mul_clear        <= 1'b0;
      intr_en          <= 1'b0;
      mul_multiplicand <= 64'h0;
      mul_multiplier   <= 64'h0;
      result           <= 128'h0;
      bus.s_dout       <= 64'h0;
    end else begin
      mul_start  <= start_req;
      mul_clear  <= clear_req;
      bus.s_dout <= rd_en ? rd_data : 64'h0;
      if (wr_en && (idx == 3'd3)) intr_en <= bus.s_din[0];
      if (wr_en && (state_q != ST_BUSY)) begin
        if (idx == 3'd4) mul_multiplicand <= bus.s_din;
        if (idx == 3'd5) mul_multiplier   <= bus.s_din;
      end
      if (clear_req)      result <= 128'h0;
      else if (done_take) result <= mul_result;
    end
  end

  assign interrupt = (state_q == ST_DONE) && intr_en;

endmodule

// File: tb/tb_mul_slave.sv
// Directed bench for mul_slave: the bench plays both bus master and multiplier core.
module tb_mul_slave;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          interrupt, mul_start, mul_clear;
  logic [63:0]   mul_multiplicand, mul_multiplier;
  logic [127:0]  mul_result = '0;
  logic          mul_done = 1'b0;
  logic [63:0]   rd;
  int            vectors = 0;
  int            miscompares = 0;

  localparam logic [7:0] A_OPSTART = 8'h00, A_OPCLEAR = 8'h08, A_OPDONE = 8'h10,
                         A_INTR_EN = 8'h18, A_MCAND = 8'h20, A_MPLIER = 8'h28,
                         A_RES_H = 8'h30, A_RES_L = 8'h38;
  localparam logic [63:0] NEG5  = 64'hFFFF_FFFF_FFFF_FFFB;
  localparam logic [63:0] NEG15 = 64'hFFFF_FFFF_FFFF_FFF1;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  mul_slave_if bus();

  mul_slave dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .interrupt(interrupt),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_start(mul_start), .mul_clear(mul_clear),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [7:0] a, input logic [63:0] d);
    @(negedge clk);
    bus.s_sel = 1'b1; bus.s_wr = 1'b1; bus.s_addr = a; bus.s_din = d;
    @(posedge clk); #1;
    bus.s_sel = 1'b0; bus.s_wr = 1'b0; bus.s_din = '0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [63:0] d);
    @(negedge clk);
    bus.s_sel = 1'b1; bus.s_wr = 1'b0; bus.s_addr = a;
    @(posedge clk); #1;
    d = bus.s_dout;
    bus.s_sel = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #2;
    vectors++;
    if ({interrupt, mul_start, mul_clear, mul_multiplicand, mul_multiplier, bus.s_dout} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got irq=%b st=%b clr=%b a=%h b=%h dout=%h required all 0",
               interrupt, mul_start, mul_clear, mul_multiplicand, mul_multiplier, bus.s_dout);
    end
    @(negedge clk); reset_n = 1'b1;
    bus_read(A_OPDONE, rd);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL reset_opdone: got %h required 0", rd); end
  endtask

  task automatic test_basic_multiply;
    bus_write(A_MCAND, 64'd3);
    bus_write(A_MPLIER, NEG5);
    bus_write(A_INTR_EN, 64'd1);
    vectors++;
    if (mul_multiplicand !== 64'd3 || mul_multiplier !== NEG5) begin
      miscompares++; $display("FAIL operand_out: got a=%h b=%h required 3/%h", mul_multiplicand, mul_multiplier, NEG5);
    end
    bus_write(A_OPSTART, 64'd1);
    vectors++;
    if (mul_start !== 1'b1 || interrupt !== 1'b0) begin
      miscompares++; $display("FAIL start_pulse_high: got start=%b irq=%b required 1/0", mul_start, interrupt);
    end
    @(posedge clk); #1;
    vectors++;
    if (mul_start !== 1'b0) begin miscompares++; $display("FAIL start_pulse_low: got %b required 0", mul_start); end
    bus_read(A_OPDONE, rd);
    vectors++;
    if (rd !== 64'd2) begin miscompares++; $display("FAIL busy_status: got %h required 2", rd); end
    repeat (30) @(posedge clk);
    @(negedge clk); mul_result = {ONES, NEG15}; mul_done = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (interrupt !== 1'b1) begin miscompares++; $display("FAIL irq_on_done: got %b required 1", interrupt); end
    mul_done = 1'b0; mul_result = '0;
    bus_read(A_RES_H, rd);
    vectors++;
    if (rd !== ONES) begin miscompares++; $display("FAIL result_h: got %h required %h", rd, ONES); end
    @(posedge clk); #1;
    vectors++;
    if (bus.s_dout !== 64'h0) begin miscompares++; $display("FAIL dout_idle_zero: got %h required 0", bus.s_dout); end
    bus_read(A_RES_L, rd);
    vectors++;
    if (rd !== NEG15) begin miscompares++; $display("FAIL result_l: got %h required %h", rd, NEG15); end
    bus_read(A_OPDONE, rd);
    vectors++;
    if (rd !== 64'd1) begin miscompares++; $display("FAIL done_status: got %h required 1", rd); end
  endtask

  task automatic test_ignored_start;
    bus_write(A_OPSTART, 64'd1);
    vectors++;
    if (mul_start !== 1'b0) begin miscompares++; $display("FAIL start_in_done: got %b required 0", mul_start); end
    bus_write(A_RES_L, 64'h1234);
    bus_write(A_OPDONE, ONES);
    bus_read(A_RES_L, rd);
    vectors++;
    if (rd !== NEG15) begin miscompares++; $display("FAIL result_ro: got %h required %h", rd, NEG15); end
    bus_read(A_OPDONE, rd);
    vectors++;
    if (rd !== 64'd1) begin miscompares++; $display("FAIL opdone_ro: got %h required 1", rd); end
  endtask

  task automatic test_intr_enable;
    bus_write(A_INTR_EN, 64'd0);
    vectors++;
    if (interrupt !== 1'b0) begin miscompares++; $display("FAIL irq_disable: got %b required 0", interrupt); end
    bus_read(A_INTR_EN, rd);
    vectors++;
    if (rd !== 64'd0) begin miscompares++; $display("FAIL intr_en_read: got %h required 0", rd); end
    bus_write(A_INTR_EN, 64'd1);
    vectors++;
    if (interrupt !== 1'b1) begin miscompares++; $display("FAIL irq_reenable: got %b required 1", interrupt); end
  endtask

  task automatic test_operand_lock;
    bus_write(A_OPCLEAR, 64'h2);
    vectors++;
    if (mul_clear !== 1'b0 || interrupt !== 1'b1) begin
      miscompares++; $display("FAIL clear_bit0_zero: got clr=%b irq=%b required 0/1", mul_clear, interrupt);
    end
    bus_write(A_OPCLEAR, 64'd1);
    vectors++;
    if (mul_clear !== 1'b1 || interrupt !== 1'b0) begin
      miscompares++; $display("FAIL clear_pulse_high: got clr=%b irq=%b required 1/0", mul_clear, interrupt);
    end
    @(posedge clk); #1;
    vectors++;
    if (mul_clear !== 1'b0) begin miscompares++; $display("FAIL clear_pulse_low: got %b required 0", mul_clear); end
    bus_read(A_RES_L, rd);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL result_cleared: got %h required 0", rd); end
    mul_done = 1'b1;
    mul_result = 128'd99;
    bus_write(A_OPSTART, 64'd1);
    vectors++;
    if (mul_start !== 1'b1) begin miscompares++; $display("FAIL restart_pulse: got %b required 1", mul_start); end
    @(posedge clk); #1;
    mul_done = 1'b0;
    bus_read(A_OPDONE, rd);
    vectors++;
    if (rd !== 64'd2) begin miscompares++; $display("FAIL stale_done_ignored: got %h required 2", rd); end
    bus_write(A_MCAND, 64'd7);
    vectors++;
    if (mul_multiplicand !== 64'd3) begin miscompares++; $display("FAIL lock_port: got %h required 3", mul_multiplicand); end
    bus_read(A_MCAND, rd);
    vectors++;
    if (rd !== 64'd3) begin miscompares++; $display("FAIL lock_read: got %h required 3", rd); end
    @(negedge clk); mul_result = 128'd42; mul_done = 1'b1;
    @(posedge clk); #1; mul_done = 1'b0; mul_result = '0;
    bus_read(A_RES_L, rd);
    vectors++;
    if (rd !== 64'd42) begin miscompares++; $display("FAIL second_result: got %h required 42", rd); end
    bus_write(A_OPCLEAR, 64'd1);
    bus_write(A_MCAND, 64'd7);
    bus_read(A_MCAND, rd);
    vectors++;
    if (rd !== 64'd7 || mul_multiplicand !== 64'd7) begin
      miscompares++; $display("FAIL unlock_write: got read=%h port=%h required 7", rd, mul_multiplicand);
    end
  endtask

  task automatic test_clear_collision;
    bus_write(A_OPSTART, 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.s_sel = 1'b1; bus.s_wr = 1'b1; bus.s_addr = A_OPCLEAR; bus.s_din = 64'd1;
    mul_result = {64'hAAAA, 64'h5555}; mul_done = 1'b1;
    @(posedge clk); #1;
    bus.s_sel = 1'b0; bus.s_wr = 1'b0; bus.s_din = '0; mul_done = 1'b0;
    vectors++;
    if (mul_clear !== 1'b1 || interrupt !== 1'b0) begin
      miscompares++; $display("FAIL collide_clear: got clr=%b irq=%b required 1/0", mul_clear, interrupt);
    end
    @(posedge clk); #1;
    vectors++;
    if (mul_clear !== 1'b0) begin miscompares++; $display("FAIL collide_clear_low: got %b required 0", mul_clear); end
    bus_read(A_OPDONE, rd);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL collide_status: got %h required 0", rd); end
    bus_read(A_RES_L, rd);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL collide_result: got %h required 0", rd); end
    mul_result = '0;
  endtask

  task automatic test_bus_edges;
    bus_read(8'h40, rd);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL unmapped_read: got %h required 0", rd); end
    bus_read(A_OPSTART, rd);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL wo_read_0: got %h required 0", rd); end
    bus_read(A_OPCLEAR, rd);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL wo_read_1: got %h required 0", rd); end
    bus_read(8'hE0, rd);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL high_bits_read: got %h required 0", rd); end
    bus_write(8'h60, 64'd5);
    bus_read(8'h25, rd);
    vectors++;
    if (rd !== 64'd7) begin miscompares++; $display("FAIL byte_offset_read: got %h required 7", rd); end
  endtask

  task automatic test_reset_mid_busy;
    bus_write(A_OPSTART, 64'd1);
    repeat (4) @(posedge clk);
    @(negedge clk); #2; reset_n = 1'b0;
    #1;
    vectors++;
    if ({interrupt, mul_start, mul_clear, mul_multiplicand, mul_multiplier, bus.s_dout} !== '0) begin
      miscompares++;
      $display("FAIL reset_busy_outputs: got irq=%b st=%b clr=%b a=%h b=%h dout=%h required all 0",
               interrupt, mul_start, mul_clear, mul_multiplicand, mul_multiplier, bus.s_dout);
    end
    @(negedge clk); reset_n = 1'b1;
    bus_read(A_OPDONE, rd);
    vectors++;
    if (rd !== 64'h0 || mul_clear !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy_status: got %h clr=%b required 0/0", rd, mul_clear);
    end
    bus_read(A_INTR_EN, rd);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL reset_intr_en: got %h required 0", rd); end
    bus_read(A_MCAND, rd);
    vectors++;
    if (rd !== 64'h0) begin miscompares++; $display("FAIL reset_operand: got %h required 0", rd); end
  endtask

  initial begin
    bus.s_sel = 1'b0; bus.s_wr = 1'b0; bus.s_addr = '0; bus.s_din = '0;
    test_reset();
    test_basic_multiply();
    test_ignored_start();
    test_intr_enable();
    test_operand_lock();
    test_clear_collision();
    test_bus_edges();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
